// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter and burst sequencer in front of a combinational-read lookup ROM.
// Each request streams consecutive words onto a registered valid/ready response channel.
module rom_burst_arbiter #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [AW:0]   req0_len,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [AW:0]   req1_len,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_id,
  output logic          rsp_last
);

  typedef enum logic [0:0] {StIdle, StBurst} state_t;

  localparam logic [AW:0] Depth = {1'b1, {AW{1'b0}}};

  state_t        state;
  logic          prio;
  logic          id;
  logic [AW-1:0] cur_addr;
  logic [AW:0]   remaining;

  logic          grant;
  logic          win;
  logic          load;
  logic [AW-1:0] sel_addr;
  logic [AW:0]   sel_len;
  logic [AW:0]   clamp_len;

  // prio names the requester that wins a tie; gating with rst_n keeps readys low in reset.
  assign req0_ready = rst_n && (state == StIdle) && req0_valid && (!req1_valid || !prio);
  assign req1_ready = rst_n && (state == StIdle) && req1_valid && (!req0_valid || prio);
  assign grant      = req0_ready || req1_ready;
  assign win        = req1_ready;
  assign rom_addr   = cur_addr;
  assign load       = (state == StBurst) && (!rsp_valid || rsp_ready) && (remaining != '0);

  always_comb begin
    sel_addr  = win ? req1_addr : req0_addr;
    sel_len   = win ? req1_len : req0_len;
    clamp_len = (sel_len > Depth) ? Depth : sel_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      prio      <= 1'b0;
      id        <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_last  <= 1'b0;
    end else begin
      // A consumed beat retires unless a new beat replaces it below.
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        StIdle: begin
          if (grant) begin
            cur_addr  <= sel_addr;
            id        <= win;
            prio      <= !win;
            remaining <= clamp_len;
            if (clamp_len != '0) state <= StBurst;
          end
        end
        StBurst: begin
          if (load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rom_data;
            rsp_id    <= id;
            rsp_last  <= (remaining == (AW+1)'(1));
            cur_addr  <= cur_addr + AW'(1);
            remaining <= remaining - (AW+1)'(1);
            if (remaining == (AW+1)'(1)) state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
